// File: rtl/combo_stim_checker.sv
// rtl/combo_stim_checker.sv - stimulus generator and response checker for a 3-input combo_gate
//
// Purpose:
//   Steps {a,b,c} through 000..111 in ascending order. Each vector is held
//   for SETTLE_CYCLES cycles in DRIVE, then for one SAMPLE cycle. At the end
//   of that cycle, y is compared against EXP_TRUTH[{a,b,c}]. After the last
//   vector, the block reports a one-cycle done pulse and pass/fail, plus an
//   error count and a per-vector failure map. These stats are held until
//   the next accepted start.
//
// Parameters:
//   EXP_TRUTH      expected y per vector, bit index = {a,b,c}
//   SETTLE_CYCLES  DRIVE cycles per vector before sampling, 1..15
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, honoured only in IDLE
//   y          in   response from combo_gate
//   a, b, c    out  registered stimulus, a is the MSB
//   busy       out  high in DRIVE and SAMPLE
//   done       out  one-cycle pulse when a run completes
//   pass       out  run result (no mismatches), held until next start
//   err_count  out  number of mismatching vectors, 0..8
//   fail_vec   out  bit i set when vector i mismatched

`timescale 1ns/1ps

module combo_stim_checker #(
  parameter logic [7:0] EXP_TRUTH     = 8'b1110_1000,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
    $error("combo_stim_checker: SETTLE_CYCLES must be within 1..15");
  end

  // Settle counter value on the last DRIVE cycle of a vector
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT      stateQ, stateD;
  logic [2:0] idxQ,   idxD;
  logic [3:0] cntQ,   cntD;
  logic [2:0] abcQ,   abcD;
  logic       busyQ,  busyD;
  logic       doneQ,  doneD;
  logic       passQ,  passD;
  logic [3:0] errQ,   errD;
  logic [7:0] failQ,  failD;

  logic expBit;
  logic mismatch;

  // The mismatch flag defaults to set and is cleared only on a definite match.
  // This way an unknown y during SAMPLE is scored as a failure rather than
  // silently accepted.
  always_comb begin
    expBit   = EXP_TRUTH[idxQ];
    mismatch = 1'b1;
    if (y == expBit) begin
      mismatch = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      idxQ   <= 3'd0;
      cntQ   <= 4'd0;
      abcQ   <= 3'd0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      passQ  <= 1'b0;
      errQ   <= 4'd0;
      failQ  <= 8'd0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      cntQ   <= cntD;
      abcQ   <= abcD;
      busyQ  <= busyD;
      doneQ  <= doneD;
      passQ  <= passD;
      errQ   <= errD;
      failQ  <= failD;
    end
  end

  // The next-state logic also computes the next value of every registered
  // output. This keeps a/b/c, busy and done aligned with the state they
  // describe.
  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    cntD   = cntQ;
    abcD   = abcQ;
    busyD  = busyQ;
    doneD  = 1'b0;
    passD  = passQ;
    errD   = errQ;
    failD  = failQ;

    case (stateQ)
      IDLE: begin
        abcD  = 3'd0;
        busyD = 1'b0;
        if (start) begin
          stateD = DRIVE;
          idxD   = 3'd0;
          cntD   = 4'd0;
          abcD   = 3'd0;
          busyD  = 1'b1;
          passD  = 1'b0;
          errD   = 4'd0;
          failD  = 8'd0;
        end
      end

      DRIVE: begin
        cntD = cntQ + 4'd1;
        if (cntQ == LAST_CNT) begin
          stateD = SAMPLE;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          errD       = errQ + 4'd1;
          failD[idxQ] = 1'b1;
        end
        if (idxQ == 3'd7) begin
          stateD = DONE;
          abcD   = 3'd0;
          busyD  = 1'b0;
          doneD  = 1'b1;
          passD  = (errD == 4'd0);
        end else begin
          stateD = DRIVE;
          idxD   = idxQ + 3'd1;
          cntD   = 4'd0;
          abcD   = idxQ + 3'd1;
        end
      end

      DONE: begin
        stateD = IDLE;
        abcD   = 3'd0;
        busyD  = 1'b0;
      end

      default: begin
        stateD = IDLE;
        abcD   = 3'd0;
        busyD  = 1'b0;
      end
    endcase
  end

  assign a         = abcQ[2];
  assign b         = abcQ[1];
  assign c         = abcQ[0];
  assign busy      = busyQ;
  assign done      = doneQ;
  assign pass      = passQ;
  assign err_count = errQ;
  assign fail_vec  = failQ;

endmodule

// File: tb/tb_combo_stim_checker.sv
// tb/tb_combo_stim_checker.sv - directed self-checking bench for combo_stim_checker

`timescale 1ns/1ps

module tb_combo_stim_checker;

  logic clk;
  logic rst_n;
  logic start0, start1;
  logic y0, y1;
  logic a0, b0, c0, busy0, done0, pass0;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] fail0, fail1;

  // 0: majority, 1: y stuck 0, 2: y stuck 1, 3: majority with vector 101 inverted
  int   mode;
  logic sel;

  int passCount;
  int checkCount;

  int doneCycle;
  int donePulses;
  int abcBad;
  int busyBad;

  logic [17:0] obs0, obs1, obs;

  combo_stim_checker #(.EXP_TRUTH(8'b1110_1000), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  combo_stim_checker #(.EXP_TRUTH(8'b1110_1000), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gateModel(input logic [2:0] v, input int m);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (v == 3'b101) ? ~maj : maj;
      default: return maj;
    endcase
  endfunction

  always_comb begin
    y0   = gateModel({a0, b0, c0}, mode);
    y1   = gateModel({a1, b1, c1}, mode);
    obs0 = {a0, b0, c0, busy0, done0, pass0, err0, fail0};
    obs1 = {a1, b1, c1, busy1, done1, pass1, err1, fail1};
    obs  = sel ? obs1 : obs0;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic setStart(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Pulses start so that it is sampled at edge 0, then observes cycles
  // 1..40. Cycle k lies between edge k-1 and edge k.
  task automatic runVec(input bit repulse);
    int per;
    int expAbc;
    logic expBusy;
    per        = sel ? 2 : 3;
    doneCycle  = 0;
    donePulses = 0;
    abcBad     = 0;
    busyBad    = 0;
    @(negedge clk);
    setStart(1'b1);
    @(posedge clk);
    #1 setStart(1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 8 * per) begin
        expAbc  = (k - 1) / per;
        expBusy = 1'b1;
      end else begin
        expAbc  = 0;
        expBusy = 1'b0;
      end
      if (obs[17:15] !== 3'(expAbc)) abcBad++;
      if (obs[14] !== expBusy) busyBad++;
      if (obs[13] === 1'b1) begin
        donePulses++;
        if (doneCycle == 0) doneCycle = k;
      end
      if (repulse && k == 10) setStart(1'b1);
      if (repulse && k == 11) setStart(1'b0);
    end
  endtask

  task automatic checkRun(input string tag, input int expDone, input logic expPass,
                          input logic [3:0] expErr, input logic [7:0] expFail);
    check({tag, "_doneCycle"},  doneCycle,  expDone);
    check({tag, "_donePulses"}, donePulses, 1);
    check({tag, "_abcBad"},     abcBad,     0);
    check({tag, "_busyBad"},    busyBad,    0);
    check({tag, "_pass"},       obs[12],    expPass);
    check({tag, "_errCount"},   obs[11:8],  expErr);
    check({tag, "_failVec"},    obs[7:0],   expFail);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    mode       = 0;
    sel        = 1'b0;
    start0     = 1'b0;
    start1     = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #3;
    check("reset_outs0", obs0, 18'd0);
    check("reset_outs1", obs1, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0;
    runVec(1'b0);
    checkRun("golden", 25, 1'b1, 4'd0, 8'h00);

    mode = 1;
    runVec(1'b0);
    checkRun("stuck0", 25, 1'b0, 4'd4, 8'hE8);

    mode = 2;
    runVec(1'b0);
    checkRun("stuck1", 25, 1'b0, 4'd4, 8'h17);

    mode = 3;
    runVec(1'b0);
    checkRun("inv101", 25, 1'b0, 4'd1, 8'h20);

    // A second start during the run must be ignored
    mode = 1;
    runVec(1'b1);
    checkRun("repulse", 25, 1'b0, 4'd4, 8'hE8);
    repeat (5) @(negedge clk);
    check("hold_err", obs[11:8], 4'd4);
    check("hold_fail", obs[7:0], 8'hE8);
    check("hold_idle_busy", obs[14], 1'b0);

    // A new start clears stale stats
    mode = 0;
    runVec(1'b0);
    checkRun("rerun", 25, 1'b1, 4'd0, 8'h00);

    // Asynchronous reset while idx=4, between clock edges
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (14) @(negedge clk);
    check("midrun_idx4", obs0[17:15], 3'd4);
    check("midrun_busy", obs0[14], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", obs0, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs0, 18'd0);
    mode = 0;
    runVec(1'b0);
    checkRun("after_reset", 25, 1'b1, 4'd0, 8'h00);

    // SETTLE_CYCLES=1 build
    sel  = 1'b1;
    mode = 0;
    runVec(1'b0);
    checkRun("settle1", 17, 1'b1, 4'd0, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
